// File: rtl/game_state_controller.sv
// Breakout gameplay sequencer: lives, level, ball serve and the game-over handshake.
// Optional `AUTO_RESTART_EN` makes GAME_OVER restart a new game directly instead of returning to IDLE.
module game_state_controller #(
    parameter int START_LIVES = 3,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int MAX_LEVEL   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       ball_lost,
    input  logic       bricks_cleared,
    input  logic       game_over_complete,
    output logic       trigger_game_over,
    output logic       serve_ball,
    output logic       game_active,
    output logic [2:0] lives,
    output logic [3:0] level
);

    localparam int               CNT_W      = $clog2(SERVE_DELAY) + 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);
    localparam logic [3:0]       LEVEL_MAX  = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        LEVEL_UP,
        GAME_OVER
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_prev;
    logic             start_edge;
    logic [2:0]       lives_nxt;
    logic [3:0]       level_nxt;
    logic             trig_nxt;
    logic             serve_nxt;
    logic             active_nxt;

    assign start_edge = start_btn & ~start_prev;

    // Outputs are computed one cycle early here so every output leaves a flop.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lives_nxt = lives;
        level_nxt = level;
        trig_nxt  = 1'b0;
        serve_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    lives_nxt = LIVES_INIT;
                    level_nxt = 4'd1;
                    cnt_nxt   = '0;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (cnt == SERVE_LAST) begin
                    serve_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = PLAY;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PLAY: begin
                // A cleared wall wins over a simultaneously lost ball.
                if (bricks_cleared) begin
                    state_nxt = LEVEL_UP;
                end else if (ball_lost) begin
                    if (lives > 3'd1) begin
                        lives_nxt = lives - 3'd1;
                        cnt_nxt   = '0;
                        state_nxt = SERVE;
                    end else begin
                        lives_nxt = 3'd0;
                        trig_nxt  = 1'b1;
                        state_nxt = GAME_OVER;
                    end
                end
            end
            LEVEL_UP: begin
                level_nxt = (level < LEVEL_MAX) ? level + 4'd1 : LEVEL_MAX;
                cnt_nxt   = '0;
                state_nxt = SERVE;
            end
            GAME_OVER: begin
                lives_nxt = 3'd0;
                if (game_over_complete) begin
`ifdef AUTO_RESTART_EN
                    lives_nxt = LIVES_INIT;
                    level_nxt = 4'd1;
                    cnt_nxt   = '0;
                    state_nxt = SERVE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        active_nxt = (state_nxt == SERVE) || (state_nxt == PLAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            start_prev        <= 1'b0;
            lives             <= 3'd0;
            level             <= 4'd0;
            trigger_game_over <= 1'b0;
            serve_ball        <= 1'b0;
            game_active       <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            start_prev        <= start_btn;
            lives             <= lives_nxt;
            level             <= level_nxt;
            trigger_game_over <= trig_nxt;
            serve_ball        <= serve_nxt;
            game_active       <= active_nxt;
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench for game_state_controller: per-cycle expected outputs are queued at drive time
// and compared shortly after the following clock edge.
module tb_game_state_controller;

    localparam int SD = 4;
    localparam int SL = 3;
    localparam int ML = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic       ball_lost = 1'b0;
    logic       bricks_cleared = 1'b0;
    logic       game_over_complete = 1'b0;
    logic       trigger_game_over;
    logic       serve_ball;
    logic       game_active;
    logic [2:0] lives;
    logic [3:0] level;

    typedef struct packed {
        logic       trig;
        logic       serve;
        logic       active;
        logic [2:0] lives;
        logic [3:0] level;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string phase = "init";

    game_state_controller #(
        .START_LIVES(SL),
        .SERVE_DELAY(SD),
        .MAX_LEVEL  (ML)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start_btn         (start_btn),
        .ball_lost         (ball_lost),
        .bricks_cleared    (bricks_cleared),
        .game_over_complete(game_over_complete),
        .trigger_game_over (trigger_game_over),
        .serve_ball        (serve_ball),
        .game_active       (game_active),
        .lives             (lives),
        .level             (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic applyStimulus(input logic st, input logic lost, input logic clr, input logic goc,
                                 input logic trig, input logic srv, input logic act,
                                 input int lv, input int lvl);
        exp_t e;
        @(negedge clk);
        start_btn          = st;
        ball_lost          = lost;
        bricks_cleared     = clr;
        game_over_complete = goc;
        e.trig   = trig;
        e.serve  = srv;
        e.active = act;
        e.lives  = 3'(lv);
        e.level  = 4'(lvl);
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(posedge clk);
    endtask

    // Stays in SERVE for SD-1 cycles (first one with stray lost/clear pulses), then expects the serve pulse.
    task automatic serveWait(input int lv, input int lvl);
        for (int i = 0; i < SD - 1; i++)
            applyStimulus(1'b1, i == 0, i == 0, 1'b0, 1'b0, 1'b0, 1'b1, lv, lvl);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, lv, lvl);
    endtask

    task automatic checkResetValues(input string tag);
        #1;
        checkOutput({tag, ".trig"},   32'(trigger_game_over), 32'd0);
        checkOutput({tag, ".serve"},  32'(serve_ball),        32'd0);
        checkOutput({tag, ".active"}, 32'(game_active),       32'd0);
        checkOutput({tag, ".lives"},  32'(lives),             32'd0);
        checkOutput({tag, ".level"},  32'(level),             32'd0);
    endtask

    task automatic idleCycles(input int n, input int lvl);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, lvl);
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checkOutput({t, ".trig"},   32'(trigger_game_over), 32'(e.trig));
                checkOutput({t, ".serve"},  32'(serve_ball),        32'(e.serve));
                checkOutput({t, ".active"}, 32'(game_active),       32'(e.active));
                checkOutput({t, ".lives"},  32'(lives),             32'(e.lives));
                checkOutput({t, ".level"},  32'(level),             32'(e.level));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int lvl;
        int nxt;

        phase = "reset";
        repeat (5) @(negedge clk);
        checkResetValues("reset_hold");
        reset = 1'b1;
        idleCycles(1, 0);

        phase = "start";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
        serveWait(SL, 1);

        phase = "life_loss";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1);
        serveWait(2, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        serveWait(1, 1);

        phase = "simultaneous";
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2);
        serveWait(1, 2);

        phase = "level_sat";
        lvl = 2;
        for (int i = 0; i < 19; i++) begin
            nxt = (lvl < ML) ? lvl + 1 : ML;
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, lvl);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, nxt);
            serveWait(1, nxt);
            lvl = nxt;
        end

        phase = "game_over";
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, ML);
        phase = "game_over_wait";
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, i[0], i[1], 1'b0, 1'b0, 1'b0, 1'b0, 0, ML);

`ifdef AUTO_RESTART_EN
        phase = "auto_restart";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, SL, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
`else
        phase = "to_idle";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, ML);
        phase = "held_start";
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ML);
        phase = "restart";
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, ML);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
`endif

        phase = "reset_in_serve";
        @(negedge clk);
        reset              = 1'b0;
        start_btn          = 1'b0;
        ball_lost          = 1'b0;
        bricks_cleared     = 1'b0;
        game_over_complete = 1'b0;
        checkResetValues("reset_in_serve");
        idleCycles(2, 0);
        @(negedge clk);
        reset = 1'b1;
        phase = "after_serve_reset";
        idleCycles(6, 0);

        phase = "game3";
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, SL, 1);
        serveWait(SL, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1);
        serveWait(2, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        serveWait(1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);

        phase = "reset_in_game_over";
        @(negedge clk);
        reset = 1'b0;
        checkResetValues("reset_in_game_over");
        idleCycles(2, 0);
        @(negedge clk);
        reset = 1'b1;
        phase = "after_go_reset";
        idleCycles(6, 0);

        @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Top-level gameplay sequencer for Breakout: tracks lives and level, gates ball serve, and produces the one-cycle `trigger_game_over` strobe consumed by `game_over_display`, then waits for its `game_over_complete` before accepting a new game. Sits between the physics/collision logic (which reports lost balls and cleared walls) and the overlay renderers. All outputs are registered.

## Interface
- `START_LIVES`, 3: lives loaded at game start; legal range 1..7.
- `SERVE_DELAY`, 50_000_000: cycles spent in SERVE before `serve_ball` fires (1 s at 50 MHz); legal range ≥1.
- `MAX_LEVEL`, 15: level saturation value; legal range 1..15.

Ports:
- `clk`  in  1  50 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start_btn`  in  1  debounced start level; acted on at its rising edge only.
- `ball_lost`  in  1  1-cycle pulse: ball passed below paddle.
- `bricks_cleared`  in  1  1-cycle pulse: last brick destroyed.
- `game_over_complete`  in  1  level from `game_over_display`: overlay finished.
- `trigger_game_over`  out  1  1-cycle pulse to `game_over_display`.
- `serve_ball`  out  1  1-cycle pulse: physics launches ball from paddle.
- `game_active`  out  1  high in SERVE and PLAY; enables paddle/ball motion.
- `lives`  out  3  remaining lives.
- `level`  out  4  current level, starts at 1.

## Operation
- States: IDLE, SERVE, PLAY, LEVEL_UP, GAME_OVER.
- IDLE: waits for `start_btn` rising edge (registered previous sample; edge = now 1, prev 0). On edge: `lives`←START_LIVES, `level`←1, serve counter cleared, → SERVE.
- SERVE: counter increments each cycle; when counter == SERVE_DELAY−1: `serve_ball` pulses next cycle, → PLAY. `ball_lost`/`bricks_cleared` ignored.
- PLAY: 
  - `bricks_cleared` (priority over `ball_lost` if same cycle) → LEVEL_UP.
  - `ball_lost` with `lives` > 1: `lives` decrements, counter cleared, → SERVE.
  - `ball_lost` with `lives` == 1: `lives`←0, → GAME_OVER, `trigger_game_over` pulses on the entry cycle exactly once.
- LEVEL_UP: single-cycle state; `level` increments, saturating at MAX_LEVEL (stays MAX_LEVEL); `lives` unchanged; counter cleared; → SERVE.
- GAME_OVER: holds `lives`=0, `level` frozen. On `game_over_complete` high → IDLE (or per Configuration). `start_btn` ignored until then.
- `trigger_game_over` never asserts outside the GAME_OVER entry; never two pulses per game.
- Counter width: $clog2(SERVE_DELAY)+1; never wraps (cleared on every SERVE entry).

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): state IDLE, `trigger_game_over`=0, `serve_ball`=0, `game_active`=0, `lives`=0, `level`=0, counter=0, edge register=0.
- Reset mid-game or mid-GAME_OVER: immediate return to reset values; no pending pulse emitted after release.
- `start_btn` edge at cycle N → SERVE, `game_active`=1, `lives`/`level` valid at N+1.
- SERVE entered at cycle S → `serve_ball` high exactly at S+SERVE_DELAY, PLAY from same cycle.
- `ball_lost` at cycle N (last life) → `trigger_game_over` high at N+1 only; `game_active` low at N+1.
- `game_over_complete` high at cycle N in GAME_OVER → IDLE at N+1.
- `start_btn` held high across IDLE return does not restart (no new edge).

## Configuration
- `AUTO_RESTART_EN` defined: GAME_OVER exits on `game_over_complete` directly into a new game (reload lives/level, → SERVE) without a start edge.
- Undefined (default): GAME_OVER → IDLE; a fresh `start_btn` rising edge is required.

## Test plan
- Start: SERVE_DELAY=4, START_LIVES=3; reset low 5 cycles, release, pulse `start_btn` → `lives`=3, `level`=1, `game_active`=1; `serve_ball` pulses exactly 4 cycles after SERVE entry.
- Life loss: in PLAY pulse `ball_lost` → `lives`=2, SERVE re-entered, new `serve_ball` 4 cycles later; no `trigger_game_over`.
- Game over: three `ball_lost` pulses → `lives`=0, exactly one `trigger_game_over` pulse one cycle after third; hold `game_over_complete`=0 100 cycles → stays GAME_OVER; assert it → IDLE next cycle (AUTO_RESTART_EN off), `start_btn` still high → no restart.
- Simultaneity/level: `ball_lost` and `bricks_cleared` same cycle with `lives`=1 → `level`=2, `lives`=1, no game over; 20 clears → `level` saturates at 15.
- Reset mid-operation: pull reset low during SERVE counter=2 and again in GAME_OVER → all outputs at reset values within the same cycle, no `serve_ball`/`trigger_game_over` after release.
- AUTO_RESTART_EN defined: after game over, `game_over_complete` high → SERVE next cycle with `lives`=3, `level`=1.
